// File: rtl/uart_pkg.sv
// Shared UART definitions for the word-level TX and RX paths.
// Line levels, transmitter states and baud-rate derivation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CTS,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last clock of each bit.
// Held at zero while clear is high so a frame starts aligned.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1, reloading at every bit boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide 8N1 transmitter, LSB byte first, with per-byte CTS gating.
// All outputs are registered; the FSM owns the line and handshake.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int CLOCK_FREQ = 200_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  cts,
    output logic                  sig_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT   = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
    localparam int BTW = (BYTE_WIDTH > 2) ? $clog2(BYTE_WIDTH) : 1;
    localparam int BCW = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BTW-1:0] LAST_BIT  = BTW'(BYTE_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("uart_word_tx: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BTW-1:0]        bit_cnt;
    logic [BCW-1:0]        byte_cnt;
    logic                  bit_tick;
    logic                  baud_clear;

    assign baud_clear = (state == IDLE) || (state == CHK_CTS);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // Frame sequencer: handshake, CTS gate, start/data/stop per byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            sig_out    <= UART_IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (word_valid && word_ready) begin
                        shreg      <= word_data;
                        byte_cnt   <= '0;
                        word_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CHK_CTS;
                    end else begin
                        word_ready <= 1'b1;
                    end
                end
                CHK_CTS: begin
                    sig_out <= UART_IDLE;
                    if (cts) begin
                        sig_out <= UART_START;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_cnt <= '0;
                        sig_out <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            sig_out <= UART_IDLE;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sig_out <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (byte_cnt == LAST_BYTE) begin
                            tx_done    <= 1'b1;
                            word_ready <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= CHK_CTS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: frame-level line model plus UART decoder.
// Ten clocks per bit, so one uninterrupted word spans 404 cycles.
module tb_uart_word_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_data = '0;
    logic        word_valid = 1'b0;
    logic        cts = 1'b1;
    logic        word_ready;
    logic        sig_out;
    logic        busy;
    logic        tx_done;

    uart_word_tx #(
        .DATA_WIDTH(32),
        .BYTE_WIDTH(8),
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .cts       (cts),
        .sig_out   (sig_out),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int hs_cnt = 0;
    int done_cyc = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Cycle count and handshake timestamps.
    always @(posedge clock) begin
        cyc++;
        if (reset && word_valid && word_ready) begin
            hs_cyc = cyc;
            hs_cnt++;
        end
    end

    // Line model: each byte is a 100-cycle frame, preceded by one
    // cts-gated cycle; the word ends when the last frame ends.
    logic       m_ready = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_t = -1;
    logic [7:0] mb[$];

    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int s;
        s = t / 10;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_t     = -1;
            mb.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (m_ready && word_valid) begin
                    for (int k = 0; k < 4; k++) mb.push_back(word_data[8*k +: 8]);
                    m_ready = 1'b0;
                    m_busy  = 1'b1;
                    m_t     = -1;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (m_t < 0) begin
                if (cts) m_t = 0;
            end else begin
                m_t++;
                if (m_t == 100) begin
                    void'(mb.pop_front());
                    m_t = -1;
                    if (mb.size() == 0) begin
                        m_busy  = 1'b0;
                        m_ready = 1'b1;
                        m_done  = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        logic el;
        el = (!m_busy || m_t < 0) ? 1'b1 : frame_bit(mb[0], m_t);
        chk("sig_out", 32'(sig_out), 32'(el));
        chk("word_ready", 32'(word_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_done", 32'(tx_done), 32'(m_done));
        if (tx_done === 1'b1) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    // UART receiver: mid-bit sampling from the falling start edge.
    logic       rx_on = 1'b0;
    int         rx_off = 0;
    int         rx_sc = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rxq[$];
    int         rxs[$];

    always @(negedge clock) begin
        if (!reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (sig_out === 1'b0) begin
                rx_on  = 1'b1;
                rx_off = 0;
                rx_sc  = cyc;
            end
        end else begin
            rx_off++;
            if (rx_off >= 15 && rx_off <= 85 && (rx_off - 15) % 10 == 0)
                rx_sh = {sig_out, rx_sh[7:1]};
            if (rx_off == 95) begin
                chk("rx_stop_bit", 32'(sig_out), 32'd1);
                rxq.push_back(rx_sh);
                rxs.push_back(rx_sc);
                rx_on = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic keep);
        int c0;
        int n;
        c0 = hs_cnt;
        n = 0;
        word_data  = d;
        word_valid = 1'b1;
        while (hs_cnt == c0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (hs_cnt == c0) chk("handshake_timeout", 32'd0, 32'd1);
        if (!keep) word_valid = 1'b0;
    endtask

    task automatic wait_done(input int c0);
        int n;
        n = 0;
        while (done_cnt == c0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (done_cnt == c0) chk("tx_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_rx(input string nm, input int base, input logic [31:0] w);
        if (rxq.size() >= base + 4)
            chk(nm, {rxq[base+3], rxq[base+2], rxq[base+1], rxq[base]}, w);
        else
            chk({nm, "_count"}, 32'(rxq.size()), 32'(base + 4));
    endtask

    initial begin
        int h;
        int h2;
        int d0;
        logic [9:0] f;

        // Reset and idle
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_sig_out", 32'(sig_out), 32'd1);
        chk("rst_word_ready", 32'(word_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_release", 32'(word_ready), 32'd1);
        repeat (3) @(negedge clock);

        // Single word, first frame pinned bit by bit
        d0 = done_cnt;
        rxq.delete();
        rxs.delete();
        f = 10'b1110111010;
        send(32'hAABBCCDD, 1'b0);
        h = hs_cyc;
        for (int i = 0; i < 10; i++) begin
            while (cyc < h + 6 + 10 * i) @(negedge clock);
            chk("frame0_bit", 32'(sig_out), 32'(f[i]));
        end
        wait_done(d0);
        chk("word_len", 32'(done_cyc - h), 32'd404);
        chk_rx("single_word", 0, 32'hAABBCCDD);
        repeat (5) @(negedge clock);

        // Back-to-back words with word_valid held
        d0 = done_cnt;
        rxq.delete();
        rxs.delete();
        send(32'h00000001, 1'b1);
        h = hs_cyc;
        send(32'hFFFFFFFF, 1'b0);
        h2 = hs_cyc;
        chk("b2b_hs_gap", 32'(h2 - h), 32'd405);
        chk("b2b_done_cycle", 32'(done_cyc - h), 32'd404);
        @(negedge clock);
        chk("b2b_start_bit", 32'(sig_out), 32'd0);
        wait_done(d0 + 1);
        chk("b2b_len2", 32'(done_cyc - h2), 32'd404);
        chk_rx("b2b_word0", 0, 32'h00000001);
        chk_rx("b2b_word1", 4, 32'hFFFFFFFF);
        repeat (5) @(negedge clock);

        // Flow control stall between bytes 1 and 2
        d0 = done_cnt;
        rxq.delete();
        rxs.delete();
        send(32'h12345678, 1'b0);
        h = hs_cyc;
        while (cyc < h + 190) @(negedge clock);
        cts = 1'b0;
        while (cyc < h + 220) @(negedge clock);
        chk("stall_line", 32'(sig_out), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        while (cyc < h + 240) @(negedge clock);
        cts = 1'b1;
        wait_done(d0);
        chk("fc_len", 32'(done_cyc - h), 32'd442);
        chk_rx("fc_word", 0, 32'h12345678);
        if (rxs.size() >= 3)
            chk("fc_byte2_start", 32'(rxs[2] - h), 32'd241);
        else
            chk("fc_byte2_start_count", 32'(rxs.size()), 32'd3);
        repeat (5) @(negedge clock);

        // Mid-word reset, then a fresh word
        d0 = done_cnt;
        send(32'h33224411, 1'b0);
        h = hs_cyc;
        while (cyc < h + 150) @(negedge clock);
        chk("pre_rst_line", 32'(sig_out), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("rst_line_async", 32'(sig_out), 32'd1);
        chk("rst_ready_async", 32'(word_ready), 32'd0);
        repeat (3) @(negedge clock);
        chk("rst_ready_held", 32'(word_ready), 32'd0);
        reset = 1'b1;
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        rxq.delete();
        rxs.delete();
        send(32'hCAFEBABE, 1'b0);
        h = hs_cyc;
        wait_done(d0);
        chk("after_rst_len", 32'(done_cyc - h), 32'd404);
        chk_rx("after_rst_word", 0, 32'hCAFEBABE);
        repeat (5) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Serial transmitter for the host side of the UART word link. It accepts 32-bit words over a valid/ready handshake and sends each word as four 8N1 bytes on sig_out, least-significant byte first. It is the counterpart that drives uart_comm's sig_in, so benches and FPGA test harnesses can use it in place of hand-timed stimulus. Optional hardware flow control via cts, which is evaluated at byte boundaries.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per UART character.
CLOCK_FREQ, 200_000_000, clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (integer truncation, 1736 at defaults), derived localparam; elaboration error if below 2.
BYTES_PER_WORD, DATA_WIDTH/BYTE_WIDTH, derived localparam.

Ports:
clock       input   1           system clock, rising edge.
reset       input   1           asynchronous, active-low reset.
word_data   input   DATA_WIDTH  word to send; sampled only on handshake.
word_valid  input   1           upstream has a word.
word_ready  output  1           block can accept a word; high only in IDLE.
cts         input   1           clear-to-send, active high; sampled before each start bit.
sig_out     output  1           serial line; idles high.
busy        output  1           high from the cycle after the handshake until the return to IDLE.
tx_done     output  1           one-cycle pulse when the last stop bit of a word completes.

Behaviour:
- Reset (reset=0, asynchronous): sig_out=1, word_ready=0, busy=0, tx_done=0, FSM=IDLE, all counters=0. The first rising clock edge after release sets word_ready=1.
- Handshake: a transfer occurs on the rising edge where word_valid && word_ready. word_data is latched into a shift register, byte_cnt=0, and word_ready drops on that edge.
- FSM states:
  - IDLE: word_ready=1. Goes to CHK_CTS on handshake.
  - CHK_CTS: sig_out=1. Goes to START when cts=1; otherwise holds indefinitely.
  - START: sig_out=0 for CLKS_PER_BIT cycles.
  - DATA: BYTE_WIDTH bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: sig_out=1 for CLKS_PER_BIT cycles. Then goes to CHK_CTS if byte_cnt<BYTES_PER_WORD-1; otherwise goes to IDLE with a tx_done pulse.
- All outputs are registered. With cts=1, the start bit begins the cycle after the handshake: sig_out falls 1 cycle after the handshake edge.
- Inter-byte gap: 1 cycle through CHK_CTS when cts=1.
- Word length: BYTES_PER_WORD*(BYTE_WIDTH+2)*CLKS_PER_BIT + BYTES_PER_WORD cycles from the handshake to tx_done.
- tx_done is asserted in the same cycle that word_ready returns to 1. Back-to-back words are accepted in that cycle, with no extra idle bit.
- Baud counter: counts 0..CLKS_PER_BIT-1. It reloads at every bit boundary and is cleared on entry to START.
- cts deasserting mid-byte has no effect; the byte completes and the block stalls in CHK_CTS before the next byte.
- word_data and word_valid changes while busy are ignored.
- Reset asserted mid-word aborts immediately: sig_out=1, and the partial word is discarded.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum {IDLE, CHK_CTS, START, DATA, STOP};
  - a function clks_per_bit(freq, baud);
  - line-level constants UART_IDLE=1 and UART_START=0.
- The package is shared with the existing receive path.
- One sub-module, uart_baud_gen: parameterised CLKS_PER_BIT counter with clear input and bit_tick output. It is reusable by the RX side.

Test Plan:
Benches use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=10 and a word takes 4*10*10+4=404 cycles.
1. Reset and idle: hold reset=0 for 5 cycles, then release -> sig_out=1 throughout, word_ready=1 on the first edge after release, busy=0, tx_done=0.
2. Single word: send 0xAABBCCDD with cts=1 -> line carries bytes DD, CC, BB, AA. The first byte frame is 0,1,0,1,1,1,0,1,1,1, with every bit exactly 10 cycles. tx_done pulses 404 cycles after the handshake.
3. Back-to-back: hold word_valid=1 and send 0x00000001 then 0xFFFFFFFF -> the second handshake happens on the tx_done cycle and its start bit follows 1 cycle later. A UART model decodes 01,00,00,00,FF,FF,FF,FF.
4. Flow control: drop cts during byte 1 of 0x12345678, hold it low for 50 cycles, then raise it -> byte 0x56 completes, the line stays high for the stall, and byte 0x34 starts 1 cycle after cts rises.
5. Mid-word reset: assert reset 150 cycles into a word -> sig_out=1 asynchronously, word_ready=0 while reset is low, and no tx_done. A fresh word 0xCAFEBABE then transmits correctly.
6. Loopback: connect sig_out to uart_comm sig_in at the default parameters and send 0xAABBCCDD -> uart_comm data_out reads 0xAABBCCDD.
